// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, BUSYWAIT freeze and
// multi-cycle MDU sequencing. Define HAZARD_PERF_CNT_EN to add the STALL_CYCLES counter.
module hazard_unit #(
   parameter int unsigned MDU_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BUSYWAIT,
   input  logic [4:0] IF_ID_RS1,
   input  logic [4:0] IF_ID_RS2,
   input  logic       IF_ID_USES_RS1,
   input  logic       IF_ID_USES_RS2,
   input  logic [4:0] ID_EX_RD,
   input  logic       ID_EX_MEMREAD,
   input  logic       ID_EX_MDU,
   input  logic       BRANCH_TAKEN,
   output logic       PC_WRITE,
   output logic       IF_ID_WRITE,
   output logic       IF_ID_FLUSH,
   output logic       ID_EX_WRITE,
   output logic       ID_EX_FLUSH,
   output logic       EX_MEM_WRITE,
   output logic       EX_MEM_FLUSH
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] STALL_CYCLES
`endif
);

   typedef enum logic {
      RUN,
      MDU_BUSY
   } state_t;

   // The trigger cycle itself counts as the first EX cycle, and the release
   // cycle as the last, so the countdown starts two below the total.
   localparam logic [4:0] CNT_LOAD = 5'(MDU_CYCLES - 2);

   state_t     state;
   state_t     state_nxt;
   logic [4:0] cnt;
   logic [4:0] cnt_nxt;

   logic rs1_hit;
   logic rs2_hit;
   logic load_use;
   logic mdu_stall;

   always_comb begin
      rs1_hit   = IF_ID_USES_RS1 && (IF_ID_RS1 == ID_EX_RD);
      rs2_hit   = IF_ID_USES_RS2 && (IF_ID_RS2 == ID_EX_RD);
      load_use  = ID_EX_MEMREAD && (ID_EX_RD != '0) && (rs1_hit || rs2_hit);
      mdu_stall = ((state == RUN) && ID_EX_MDU) ||
                  ((state == MDU_BUSY) && (cnt != '0));
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      PC_WRITE     = 1'b1;
      IF_ID_WRITE  = 1'b1;
      IF_ID_FLUSH  = 1'b0;
      ID_EX_WRITE  = 1'b1;
      ID_EX_FLUSH  = 1'b0;
      EX_MEM_WRITE = 1'b1;
      EX_MEM_FLUSH = 1'b0;

      if (!RESET) begin
         PC_WRITE     = 1'b0;
         IF_ID_WRITE  = 1'b0;
         ID_EX_WRITE  = 1'b0;
         EX_MEM_WRITE = 1'b0;
         state_nxt    = RUN;
         cnt_nxt      = '0;
      end else if (BUSYWAIT) begin
         PC_WRITE     = 1'b0;
         IF_ID_WRITE  = 1'b0;
         ID_EX_WRITE  = 1'b0;
         EX_MEM_WRITE = 1'b0;
      end else if (mdu_stall) begin
         PC_WRITE     = 1'b0;
         IF_ID_WRITE  = 1'b0;
         ID_EX_WRITE  = 1'b0;
         EX_MEM_FLUSH = 1'b1;
         if (state == RUN) begin
            state_nxt = MDU_BUSY;
            cnt_nxt   = CNT_LOAD;
         end else begin
            cnt_nxt = cnt - 5'd1;
         end
      end else begin
         // Release cycle falls through here too; ID_EX_MDU is ignored because
         // the trigger term is gated by RUN.
         if (state == MDU_BUSY) begin
            state_nxt = RUN;
         end
         if (BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
         end else if (load_use) begin
            PC_WRITE    = 1'b0;
            IF_ID_WRITE = 1'b0;
            ID_EX_FLUSH = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         STALL_CYCLES <= '0;
      end else if (!PC_WRITE) begin
         STALL_CYCLES <= STALL_CYCLES + 32'd1;
      end
   end
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the RV32IM five-stage core. It reads the fields latched in the ID/EX register, the source registers of the instruction in ID, branch resolution from EX and the data-memory BUSYWAIT. From these it drives the write-enable and flush (bubble) inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It also sequences multi-cycle M-extension operations with an internal countdown FSM.

## Interface
- MDU_CYCLES, default 4: total cycles a mul/div instruction occupies EX; legal range 2..32.
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BUSYWAIT  in  1  data memory not ready; freeze the whole pipeline.
- IF_ID_RS1, IF_ID_RS2  in  5 each  source register indices of the instruction in ID.
- IF_ID_USES_RS1, IF_ID_USES_RS2  in  1 each  the ID instruction actually reads that source.
- ID_EX_RD  in  5  destination register index of the instruction in EX.
- ID_EX_MEMREAD  in  1  the instruction in EX is a load.
- ID_EX_MDU  in  1  the instruction in EX is a mul/div.
- BRANCH_TAKEN  in  1  EX resolved a taken branch or a jump (JAL/JALR).
- PC_WRITE  out  1  PC register enable.
- IF_ID_WRITE  out  1  IF/ID enable.
- IF_ID_FLUSH  out  1  clear IF/ID to a NOP.
- ID_EX_WRITE  out  1  ID/EX enable.
- ID_EX_FLUSH  out  1  load a bubble (all control bits 0) into ID/EX.
- EX_MEM_WRITE  out  1  EX/MEM enable.
- EX_MEM_FLUSH  out  1  load a bubble into EX/MEM.

## Operation
- State: FSM {RUN, MDU_BUSY} plus a 5-bit countdown CNT.
- All outputs are combinational from state and inputs. Default (RUN, no hazard): all WRITE=1, all FLUSH=0.
- Outputs are resolved in the following priority order.
- 1. RESET low: all WRITE=0, all FLUSH=0; state←RUN, CNT←0.
- 2. BUSYWAIT=1: all WRITE=0, all FLUSH=0. State and CNT hold, regardless of other inputs.
- 3. MDU stall, which applies in either case below:
  - RUN with ID_EX_MDU=1;
  - MDU_BUSY with CNT≠0.
  - Outputs: PC_WRITE=IF_ID_WRITE=ID_EX_WRITE=0, EX_MEM_FLUSH=1, EX_MEM_WRITE=1.
  - In RUN: next state MDU_BUSY, CNT←MDU_CYCLES−2.
  - In MDU_BUSY: CNT←CNT−1.
- 4. MDU_BUSY with CNT=0 (release cycle): default outputs, next state RUN.
  - ID_EX_MDU is still high in this cycle and must not retrigger.
  - Rules 5–6 still apply in this cycle.
- 5. BRANCH_TAKEN=1: IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_WRITE=1 (PC loads target). Overrides rule 6.
- 6. Load-use hazard when ID_EX_MEMREAD=1, ID_EX_RD≠0, and either:
  - IF_ID_USES_RS1 and IF_ID_RS1=ID_EX_RD; or
  - IF_ID_USES_RS2 and IF_ID_RS2=ID_EX_RD.
  - Outputs: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1 (one bubble); EX/MEM advances.
  - No state is kept; the bubble clears the match on the next cycle.
- A destination of x0 never causes a stall.
- BRANCH_TAKEN together with ID_EX_MDU cannot occur; if both are high, MDU has priority.

## Timing
- Hazard response (stall/flush) takes effect at the same clock edge it is detected: zero-cycle detect.
- Load-use stall: exactly 1 cycle. Branch flush: exactly 2 bubbles (IF/ID and ID/EX).
- MDU instruction: stays in EX for MDU_CYCLES non-BUSYWAIT cycles.
  - PC frozen for MDU_CYCLES−1 cycles.
  - EX_MEM receives MDU_CYCLES−1 bubbles.
- Back-to-back MDU instructions: the second triggers on the cycle after the release edge.
- BUSYWAIT cycles extend any stall 1:1; CNT does not decrement while BUSYWAIT=1.
- Reset asserted mid-MDU: FSM returns to RUN asynchronously. After deassertion, behaviour is as after power-up.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds output STALL_CYCLES [31:0].
  - Increments on every clock edge where RESET is high and PC_WRITE=0.
  - Wraps 0xFFFFFFFF→0; resets to 0.
- HAZARD_PERF_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Load-use: ID_EX_MEMREAD=1, ID_EX_RD=5, IF_ID_RS2=5, USES_RS2=1 → one cycle of PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1, then defaults. Repeat with RD=0 → no stall.
- Branch: BRANCH_TAKEN=1 with a simultaneous load-use match → IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_WRITE=1; no stall.
- MDU, MDU_CYCLES=4: ID_EX_MDU held high → PC_WRITE=0 and EX_MEM_FLUSH=1 for 3 cycles; 4th cycle defaults; no retrigger.
- BUSYWAIT mid-MDU: BUSYWAIT=1 for 2 cycles at the second stall cycle → all WRITE=0; total PC freeze 5 cycles.
- Reset mid-MDU: RESET low during MDU_BUSY → all outputs 0 immediately; after release with ID_EX_MDU=0 → defaults.
- HAZARD_PERF_CNT_EN: run the load-use and MDU scenarios → STALL_CYCLES=4; preload near wrap → wraps to 0.
